id_issue_ctrl: RTL
==================

Name: id_issue_ctrl

Overview:
- Issue controller for the decode stage. It sits between the decoder outputs and the execute stage.
- Tracks outstanding register writes in a 32-entry scoreboard and blocks issue on RAW/WAW hazards, on a full in-flight window, and for FENCE/SYSTEM until the window drains.
- Generates the IF→ID stall handshake, the ID→EX issue strobe, and a registered stall-reason and stall-cycle counter for debug and perf.

Parameters:
- MAX_OUTSTANDING, 4, maximum issued-but-not-retired register-writing instructions (1..15).
- CNT_W, 4, width of the Outstanding counter; must hold MAX_OUTSTANDING.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- IdValid  in  1  decode stage holds a valid instruction
- IdReady  out  1  decode stage can accept the next instruction from IF
- OpCode  in  7  decoded opcode of the instruction in ID
- Rs1ReadEnable  in  1  rs1 is a source operand
- Rs1Addr  in  5  rs1 index
- Rs2ReadEnable  in  1  rs2 is a source operand
- Rs2Addr  in  5  rs2 index
- RdWriteEnable  in  1  instruction writes rd
- RdAddr  in  5  rd index
- ExReady  in  1  execute stage can accept an instruction this cycle
- IssueValid  out  1  instruction in ID is issued to EX this cycle
- FlushIn  in  1  kill the instruction currently in ID (branch redirect)
- WbValid  in  1  writeback retires a register write this cycle
- WbAddr  in  5  retired rd index
- PendingMask  out  32  scoreboard; bit n = write to xn outstanding
- Outstanding  out  CNT_W  count of outstanding writers
- State  out  2  registered stall reason: 0 RUN, 1 HAZ, 2 FULL, 3 DRAIN
- StallCycles  out  32  saturating count of stalled cycles

Behaviour:
- Reset (synchronous, rst=1 at clk edge): PendingMask=0, Outstanding=0, State=RUN, StallCycles=0. Combinational outputs follow from inputs.
- retire = WbValid && WbAddr!=0 && PendingMask[WbAddr]. A retire to a non-pending register or to x0 is ignored, so Outstanding never underflows.
- Effective pending set P = PendingMask with bit WbAddr cleared when retire (same-cycle writeback bypass).
- haz = (Rs1ReadEnable && Rs1Addr!=0 && P[Rs1Addr]) || (Rs2ReadEnable && Rs2Addr!=0 && P[Rs2Addr]) || (RdWriteEnable && RdAddr!=0 && P[RdAddr]).
- writer = RdWriteEnable && RdAddr!=0.
- full = writer && (Outstanding - retire) == MAX_OUTSTANDING.
- drain = (OpCode==7'b0001111 || OpCode==7'b1110011) && Outstanding!=0. This uses the registered count with no bypass.
- IssueValid = IdValid && ExReady && !FlushIn && !haz && !full && !drain. This is combinational, zero latency.
- IdReady = !IdValid || IssueValid || FlushIn. This is combinational.
- Next PendingMask = (PendingMask & ~retire-bit) | (IssueValid && writer ? bit RdAddr : 0). When issue and retire target the same register in one cycle, issue wins and the bit ends set.
- Next Outstanding = Outstanding + (IssueValid && writer) - retire.
- Next State when IdValid && !FlushIn && !IssueValid: DRAIN if drain, else HAZ if haz, else FULL if full, else RUN (ExReady backpressure only). In all other cases next State is RUN.
- StallCycles increments each cycle IdValid && !FlushIn && !IssueValid, and holds at 32'hFFFF_FFFF.
- FlushIn has priority over all other conditions. It suppresses issue, forces IdReady=1, and leaves PendingMask and Outstanding affected only by retire. Already-issued instructions still retire normally.
- Bit 0 of PendingMask is constant 0.
- rst asserted mid-operation clears all state on that edge. Writebacks arriving after reset are ignored as non-pending.

Test Plan:
1. Reset: assert rst 2 cycles with random inputs → PendingMask=0, Outstanding=0, State=0, StallCycles=0; IdValid=0 gives IdReady=1, IssueValid=0.
2. RAW with bypass: issue writer rd=5 (PendingMask=0x20, Outstanding=1). Next, rs1=5, ExReady=1 → IssueValid=0, State=HAZ next cycle, StallCycles=1. Then WbValid=1, WbAddr=5 in the same cycle → IssueValid=1, PendingMask=0.
3. Full window: issue writers rd=1..4 → Outstanding=4. Writer rd=6 → IssueValid=0, State=FULL. Same cycle WbAddr=1 → issue, Outstanding stays 4, PendingMask=0x5C.
4. Drain: Outstanding=2 (x7, x8), OpCode=0001111 → State=DRAIN until both retire. Issues the cycle after Outstanding registers 0.
5. Flush over hazard: a HAZ-blocked instruction with FlushIn=1 → IssueValid=0, IdReady=1, State=RUN, StallCycles unchanged. A concurrent WbAddr retire still clears its bit.
6. x0 and saturation: writer rd=0 issues with PendingMask unchanged, and rs1=0 never blocks. Preload StallCycles to 0xFFFF_FFFE via a long stall → counter holds at 0xFFFF_FFFF.

Source files
------------

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: scoreboard-based RAW/WAW blocking, in-flight window limit, FENCE/SYSTEM drain.
// Issue/IdReady are combinational (zero latency); scoreboard, stall reason and stall counter are registered.
module id_issue_ctrl #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IdValid,
    output logic             IdReady,
    input  logic [6:0]       OpCode,
    input  logic             Rs1ReadEnable,
    input  logic [4:0]       Rs1Addr,
    input  logic             Rs2ReadEnable,
    input  logic [4:0]       Rs2Addr,
    input  logic             RdWriteEnable,
    input  logic [4:0]       RdAddr,
    input  logic             ExReady,
    output logic             IssueValid,
    input  logic             FlushIn,
    input  logic             WbValid,
    input  logic [4:0]       WbAddr,
    output logic [31:0]      PendingMask,
    output logic [CNT_W-1:0] Outstanding,
    output logic [1:0]       State,
    output logic [31:0]      StallCycles
);

    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HAZ   = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [31:0]       pending_q;
    logic [31:0]       pending_d;
    logic [CNT_W-1:0]  outstanding_q;
    logic [CNT_W-1:0]  outstanding_d;
    logic [31:0]       stall_cycles_q;

    logic              retire;
    logic [31:0]       retire_vec;
    logic [31:0]       pend_eff;
    logic              haz;
    logic              writer;
    logic              full;
    logic              drain;
    logic              issue;
    logic              stalled;
    logic [CNT_W-1:0]  cnt_after_retire;

    // Retire only counts when the bit is actually pending; keeps the counter from underflowing.
    assign retire     = WbValid && (WbAddr != 5'd0) && pending_q[WbAddr];
    assign retire_vec = retire ? (32'd1 << WbAddr) : 32'd0;
    assign pend_eff   = pending_q & ~retire_vec;

    assign haz = (Rs1ReadEnable && (Rs1Addr != 5'd0) && pend_eff[Rs1Addr])
              || (Rs2ReadEnable && (Rs2Addr != 5'd0) && pend_eff[Rs2Addr])
              || (RdWriteEnable && (RdAddr  != 5'd0) && pend_eff[RdAddr]);

    assign writer           = RdWriteEnable && (RdAddr != 5'd0);
    assign cnt_after_retire = outstanding_q - CNT_W'(retire);
    assign full             = writer && (cnt_after_retire == CNT_W'(MAX_OUTSTANDING));

    // Serialising ops wait on the registered count, so they issue one cycle after the last retire.
    assign drain = ((OpCode == OP_FENCE) || (OpCode == OP_SYSTEM)) && (outstanding_q != '0);

    assign issue   = IdValid && ExReady && !FlushIn && !haz && !full && !drain;
    assign stalled = IdValid && !FlushIn && !issue;

    assign IssueValid  = issue;
    assign IdReady     = !IdValid || issue || FlushIn;
    assign PendingMask = pending_q;
    assign Outstanding = outstanding_q;
    assign State       = state_q;
    assign StallCycles = stall_cycles_q;

    always_comb begin
        pending_d = pend_eff;
        if (issue && writer) begin
            pending_d = pending_d | (32'd1 << RdAddr);
        end
        pending_d[0] = 1'b0;

        outstanding_d = outstanding_q + CNT_W'(issue && writer) - CNT_W'(retire);

        state_d = ST_RUN;
        if (stalled) begin
            if (drain) begin
                state_d = ST_DRAIN;
            end else if (haz) begin
                state_d = ST_HAZ;
            end else if (full) begin
                state_d = ST_FULL;
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            pending_q      <= 32'd0;
            outstanding_q  <= '0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            if (stalled && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
        end
    end

endmodule
